// File: rtl/iterative_divider_64_32_if.sv
// Operand/result bundle for the 64/32 restoring divider.
// Handshake: start is level-sampled on an enabled edge only while the divider is idle
// or done; done pulses for one enabled cycle when Q/R/dz are valid; busy marks RUN.
interface iterative_divider_64_32_if;
  logic        enable;
  logic        start;
  logic [63:0] A;
  logic [31:0] B;
  logic [63:0] Q;
  logic [31:0] R;
  logic        busy;
  logic        done;
  logic        dz;
  logic [1:0]  state;

  modport master (
    output enable, start, A, B,
    input  Q, R, busy, done, dz, state
  );

  modport slave (
    input  enable, start, A, B,
    output Q, R, busy, done, dz, state
  );
endinterface

// File: rtl/iterative_divider_64_32.sv
// Unsigned 64/32 restoring divider producing one quotient bit per enabled cycle
// through a single shared 33-bit ripple subtractor.
module sub #(
  parameter int N = 33
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] diff,
  output logic         cout
);
  logic [N:0] c;

  // a - b computed as a + ~b + cin; cout=1 means no borrow.
  always_comb begin
    c    = '0;
    diff = '0;
    c[0] = cin;
    for (int i = 0; i < N; i++) begin
      diff[i]  = a[i] ^ ~b[i] ^ c[i];
      c[i+1]   = (a[i] & ~b[i]) | (a[i] & c[i]) | (~b[i] & c[i]);
    end
  end

  assign cout = c[N];
endmodule

module iterative_divider_64_32 (
  input  logic                      clk,
  input  logic                      rst,
  iterative_divider_64_32_if.slave  bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [63:0] d_q;
  logic [31:0] v_q;
  logic [32:0] p_q;
  logic [63:0] q_q;
  logic [31:0] r_q;
  logic [5:0]  count;
  logic        busy_q;
  logic        done_q;
  logic        dz_q;

  logic [32:0] shifted;
  logic [32:0] diff;
  logic        no_borrow;
  logic [32:0] p_next;
  logic        unused_p_msb;

  assign shifted = {p_q[31:0], d_q[63]};

  sub #(.N(33)) u_sub (
    .a    (shifted),
    .b    ({1'b0, v_q}),
    .cin  (1'b1),
    .diff (diff),
    .cout (no_borrow)
  );

  assign p_next = no_borrow ? diff : shifted;
  // After a restore the remainder fits in 32 bits, so P[32] never feeds the next step.
  assign unused_p_msb = p_q[32];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      d_q    <= '0;
      v_q    <= '0;
      p_q    <= '0;
      q_q    <= '0;
      r_q    <= '0;
      count  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dz_q   <= 1'b0;
    end else if (bus.enable) begin
      unique case (state)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            if (bus.B != 32'd0) begin
              d_q    <= bus.A;
              v_q    <= bus.B;
              p_q    <= '0;
              q_q    <= '0;
              count  <= '0;
              dz_q   <= 1'b0;
              busy_q <= 1'b1;
              state  <= RUN;
            end else begin
              q_q    <= '1;
              r_q    <= bus.A[31:0];
              dz_q   <= 1'b1;
              done_q <= 1'b1;
              state  <= DONE;
            end
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          p_q   <= p_next;
          q_q   <= {q_q[62:0], no_borrow};
          d_q   <= {d_q[62:0], 1'b0};
          count <= count + 6'd1;
          if (count == 6'd63) begin
            r_q    <= p_next[31:0];
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Q     = q_q;
  assign bus.R     = r_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.dz    = dz_q;
  assign bus.state = state;
endmodule
